// File: rtl/pci_pkg.sv
// Shared PCI definitions: memory commands, register-window constants and the
// target state encoding, used by both the target and any initiator model.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'h6;
  localparam logic [3:0] CMD_MEM_WRITE = 4'h7;

  // Register index that returns the device ID and ignores writes
  localparam logic [1:0] DEV_ID_IDX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DATA   = 2'd2,
    ST_TURN   = 2'd3
  } tgt_state_e;

  function automatic logic is_mem_cmd(input logic [3:0] cmd);
    return (cmd == CMD_MEM_READ) || (cmd == CMD_MEM_WRITE);
  endfunction

endpackage

// File: rtl/pci_target_regs_if.sv
// Handshake and command signals between a PCI initiator and a target.
// The multiplexed adr bus stays a separate inout port on the target.
interface pci_target_regs_if;

  logic       frame_;
  logic       irdy_;
  logic [3:0] cbe;
  logic       devsel_;
  logic       trdy_;

  modport master (
    output frame_,
    output irdy_,
    output cbe,
    input  devsel_,
    input  trdy_
  );

  modport slave (
    input  frame_,
    input  irdy_,
    input  cbe,
    output devsel_,
    output trdy_
  );

endinterface

// File: rtl/pci_target_regfile.sv
// Three read/write 32-bit registers plus a constant ID register, with a
// zero-latency read mux for the target's data phase.
module pci_target_regfile
  import pci_pkg::*;
#(
  parameter logic [31:0] DEV_ID = 32'h5043_4901
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        i_we,
  input  logic [1:0]  i_idx,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_reg0
);

  logic [31:0] r_reg0;
  logic [31:0] r_reg1;
  logic [31:0] r_reg2;

  // Register storage; the ID slot silently drops writes
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_reg0 <= 32'h0000_0000;
      r_reg1 <= 32'h0000_0000;
      r_reg2 <= 32'h0000_0000;
    end else if (i_we && (i_idx != DEV_ID_IDX)) begin
      case (i_idx)
        2'd0:    r_reg0 <= i_wdata;
        2'd1:    r_reg1 <= i_wdata;
        2'd2:    r_reg2 <= i_wdata;
        default: r_reg0 <= r_reg0;
      endcase
    end
  end

  // Read mux
  always_comb begin
    o_rdata = DEV_ID;
    case (i_idx)
      2'd0:    o_rdata = r_reg0;
      2'd1:    o_rdata = r_reg1;
      2'd2:    o_rdata = r_reg2;
      default: o_rdata = DEV_ID;
    endcase
  end

  assign o_reg0 = r_reg0;

endmodule

// File: rtl/pci_target_regs.sv
// PCI memory target exposing four 32-bit registers in a 16-byte window.
// One data phase per transaction; the FSM and the adr/devsel_/trdy_ drive live here.
module pci_target_regs
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter logic [31:0] DEV_ID       = 32'h5043_4901,
  parameter int unsigned IRDY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_,
  pci_target_regs_if.slave bus,
  inout  wire  [31:0]      adr,
  output logic [31:0]      reg0_out
);

  localparam int unsigned     TO_W    = $clog2(IRDY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IRDY_TIMEOUT - 1);

  tgt_state_e      r_state;
  tgt_state_e      w_state_nxt;
  logic            r_frame_q;
  logic            r_is_write;
  logic [1:0]      r_idx;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_devsel_n;
  logic            r_trdy_n;
  logic            w_hit;
  logic            w_we;
  logic            w_adr_oe;
  logic [31:0]     w_rdata;

  // r_frame_q resets low so a frame_ already low at reset release is not a hit
  assign w_hit = !bus.frame_ && r_frame_q && is_mem_cmd(bus.cbe) &&
                 (adr[31:4] == BASE_ADDR[31:4]);

  // Next-state and register write strobe
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state_nxt = ST_DECODE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (!bus.irdy_ && !r_trdy_n) begin
          w_state_nxt = ST_TURN;
          w_we        = r_is_write;
        end else if (bus.irdy_ && (r_to_cnt == TO_LAST)) begin
          w_state_nxt = ST_TURN;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_TURN: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and frame_ history for falling-edge detection
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state   <= ST_IDLE;
      r_frame_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frame_q <= bus.frame_;
    end
  end

  // Capture register index and direction on an accepted hit
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_idx      <= 2'd0;
      r_is_write <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_hit) begin
      r_idx      <= adr[3:2];
      r_is_write <= (bus.cbe == CMD_MEM_WRITE);
    end
  end

  // Consecutive irdy_-high cycles spent in DATA
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_DATA) && bus.irdy_) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  // devsel_ covers all of DATA; trdy_ joins one edge later and drops on exit
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_devsel_n <= 1'b1;
      r_trdy_n   <= 1'b1;
    end else begin
      r_devsel_n <= (w_state_nxt != ST_DATA);
      r_trdy_n   <= !((r_state == ST_DATA) && (w_state_nxt == ST_DATA));
    end
  end

  assign bus.devsel_ = r_devsel_n;
  assign bus.trdy_   = r_trdy_n;

  assign w_adr_oe = (r_state == ST_DATA) && !r_is_write;
  assign adr      = w_adr_oe ? w_rdata : {32{1'bz}};

  pci_target_regfile #(
    .DEV_ID (DEV_ID)
  ) u_regfile (
    .clk     (clk),
    .rst_    (rst_),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (adr),
    .o_rdata (w_rdata),
    .o_reg0  (reg0_out)
  );

endmodule
